// File: rtl/wolverine_aeg_dispatch.sv
// Wolverine dispatch consumer: holds the AEG register file, serves host
// register reads/writes, turns dispatched instructions into a one-cycle
// start pulse, watches core busy/done and reports idle/stall/exceptions.
module wolverine_aeg_dispatch #(
    parameter int AEG_CNT = 16,
    parameter int TIMEOUT = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wolv_dispInstValid,
    input  logic [4:0]  wolv_dispInstData,
    input  logic [17:0] wolv_dispRegID,
    input  logic        wolv_dispRegRead,
    input  logic        wolv_dispRegWrite,
    input  logic [63:0] wolv_dispRegWrData,
    output logic [17:0] wolv_dispAegCnt,
    output logic [15:0] wolv_dispException,
    output logic        wolv_dispIdle,
    output logic        wolv_dispRtnValid,
    output logic [63:0] wolv_dispRtnData,
    output logic        wolv_dispStall,
    output logic        wolv_start,
    output logic [4:0]  wolv_startOp,
    input  logic        wolv_done,
    input  logic [17:0] wolv_aegRdIdx,
    output logic [63:0] wolv_aegRdData,
    input  logic        wolv_resWrValid,
    input  logic [17:0] wolv_resWrIdx,
    input  logic [63:0] wolv_resWrData
);

    localparam int          IDX_W     = (AEG_CNT > 1) ? $clog2(AEG_CNT) : 1;
    localparam logic [17:0] AEG_CNT_C = 18'(AEG_CNT);
    // Last counter value before the watchdog fires (unused when TIMEOUT is 0).
    localparam logic [31:0] WD_LAST_C = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_BUSY   = 2'd2
    } state_t;

    state_t          state_r;
    state_t          next_state_s;
    logic [63:0]     aeg_r [AEG_CNT];
    logic [31:0]     wd_cnt_r;
    logic [5:0]      exc_r;
    logic [5:0]      exc_set_s;
    logic            idle_r;
    logic            stall_r;
    logic            start_r;
    logic [4:0]      start_op_r;
    logic            rtn_valid_r;
    logic [63:0]     rtn_data_r;

    logic            host_in_s;
    logic            core_wr_in_s;
    logic            core_rd_in_s;
    logic            wd_expire_s;
    logic            host_wr_ok_s;
    logic            core_wr_ok_s;
    logic [IDX_W-1:0] host_idx_s;
    logic [IDX_W-1:0] core_wr_idx_s;
    logic [IDX_W-1:0] core_rd_idx_s;

    assign host_in_s     = wolv_dispRegID < AEG_CNT_C;
    assign core_wr_in_s  = wolv_resWrIdx < AEG_CNT_C;
    assign core_rd_in_s  = wolv_aegRdIdx < AEG_CNT_C;
    assign host_idx_s    = wolv_dispRegID[IDX_W-1:0];
    assign core_wr_idx_s = wolv_resWrIdx[IDX_W-1:0];
    assign core_rd_idx_s = wolv_aegRdIdx[IDX_W-1:0];
    assign wd_expire_s   = (TIMEOUT != 0) && (wd_cnt_r == WD_LAST_C);
    assign host_wr_ok_s  = wolv_dispRegWrite && host_in_s && (state_r == ST_IDLE);
    assign core_wr_ok_s  = wolv_resWrValid && core_wr_in_s;

    // Next-state logic and per-cycle exception events.
    always_comb begin
        next_state_s = state_r;
        exc_set_s    = 6'd0;
        case (state_r)
            ST_IDLE: begin
                if (wolv_dispInstValid) begin
                    next_state_s = ST_LAUNCH;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                next_state_s = ST_BUSY;
            end
            ST_BUSY: begin
                if (wolv_done) begin
                    next_state_s = ST_IDLE;
                end else if (wd_expire_s) begin
                    next_state_s = ST_IDLE;
                    exc_set_s[3] = 1'b1;
                end else begin
                    next_state_s = ST_BUSY;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
        exc_set_s[0] = wolv_dispInstValid && (state_r != ST_IDLE);
        exc_set_s[1] = (wolv_dispRegRead || wolv_dispRegWrite) && !host_in_s;
        exc_set_s[4] = wolv_dispRegWrite && (state_r != ST_IDLE);
        exc_set_s[5] = wolv_resWrValid && !core_wr_in_s;
    end

    // State register and BUSY watchdog counter (cleared outside BUSY).
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            wd_cnt_r <= 32'd0;
        end else begin
            state_r <= next_state_s;
            if (state_r == ST_BUSY) begin
                wd_cnt_r <= wd_cnt_r + 32'd1;
            end else begin
                wd_cnt_r <= 32'd0;
            end
        end
    end

    // AEG file update; host write is applied last so it wins an index collision.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < AEG_CNT; i++) begin
                aeg_r[i] <= 64'd0;
            end
        end else begin
            if (core_wr_ok_s) begin
                aeg_r[core_wr_idx_s] <= wolv_resWrData;
            end
            if (host_wr_ok_s) begin
                aeg_r[host_idx_s] <= wolv_dispRegWrData;
            end
        end
    end

    // Registered host-facing status, start pulse, read return and sticky exceptions.
    always_ff @(posedge clock) begin
        if (reset) begin
            idle_r      <= 1'b1;
            stall_r     <= 1'b0;
            start_r     <= 1'b0;
            start_op_r  <= 5'd0;
            rtn_valid_r <= 1'b0;
            rtn_data_r  <= 64'd0;
            exc_r       <= 6'd0;
        end else begin
            idle_r      <= (next_state_s == ST_IDLE);
            stall_r     <= (next_state_s != ST_IDLE);
            start_r     <= (next_state_s == ST_LAUNCH);
            if ((state_r == ST_IDLE) && wolv_dispInstValid) begin
                start_op_r <= wolv_dispInstData;
            end
            rtn_valid_r <= wolv_dispRegRead;
            rtn_data_r  <= (wolv_dispRegRead && host_in_s) ? aeg_r[host_idx_s] : 64'd0;
            exc_r       <= exc_r | exc_set_s;
        end
    end

    assign wolv_dispAegCnt    = AEG_CNT_C;
    assign wolv_dispException = {10'd0, exc_r};
    assign wolv_dispIdle      = idle_r;
    assign wolv_dispStall     = stall_r;
    assign wolv_start         = start_r;
    assign wolv_startOp       = start_op_r;
    assign wolv_dispRtnValid  = rtn_valid_r;
    assign wolv_dispRtnData   = rtn_data_r;
    assign wolv_aegRdData     = core_rd_in_s ? aeg_r[core_rd_idx_s] : 64'd0;

endmodule

// File: tb/tb_wolverine_aeg_dispatch.sv
// Self-checking bench for wolverine_aeg_dispatch: table of host register
// accesses with a read-return scoreboard, plus hand-written dispatch,
// range-error, priority, watchdog and mid-BUSY reset sequences.
module tb_wolverine_aeg_dispatch;

    logic        clock = 1'b0;
    logic        reset;
    logic        inst_valid;
    logic [4:0]  inst_data;
    logic [17:0] reg_id;
    logic        reg_read;
    logic        reg_write;
    logic [63:0] reg_wr_data;
    logic        done;
    logic [17:0] aeg_rd_idx;
    logic        res_wr_valid;
    logic [17:0] res_wr_idx;
    logic [63:0] res_wr_data;

    logic [17:0] d0_aeg_cnt,  d1_aeg_cnt;
    logic [15:0] d0_exc,      d1_exc;
    logic        d0_idle,     d1_idle;
    logic        d0_rtn_v,    d1_rtn_v;
    logic [63:0] d0_rtn_d,    d1_rtn_d;
    logic        d0_stall,    d1_stall;
    logic        d0_start,    d1_start;
    logic [4:0]  d0_op,       d1_op;
    logic [63:0] d0_aeg_rd,   d1_aeg_rd;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q [$];

    typedef struct {
        logic        rd;
        logic        wr;
        logic [17:0] idx;
        logic [63:0] wdata;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [10];

    always #5 clock = ~clock;

    wolverine_aeg_dispatch #(.AEG_CNT(16), .TIMEOUT(0)) dut0 (
        .clock(clock), .reset(reset),
        .wolv_dispInstValid(inst_valid), .wolv_dispInstData(inst_data),
        .wolv_dispRegID(reg_id), .wolv_dispRegRead(reg_read),
        .wolv_dispRegWrite(reg_write), .wolv_dispRegWrData(reg_wr_data),
        .wolv_dispAegCnt(d0_aeg_cnt), .wolv_dispException(d0_exc),
        .wolv_dispIdle(d0_idle), .wolv_dispRtnValid(d0_rtn_v),
        .wolv_dispRtnData(d0_rtn_d), .wolv_dispStall(d0_stall),
        .wolv_start(d0_start), .wolv_startOp(d0_op), .wolv_done(done),
        .wolv_aegRdIdx(aeg_rd_idx), .wolv_aegRdData(d0_aeg_rd),
        .wolv_resWrValid(res_wr_valid), .wolv_resWrIdx(res_wr_idx),
        .wolv_resWrData(res_wr_data)
    );

    wolverine_aeg_dispatch #(.AEG_CNT(16), .TIMEOUT(8)) dut1 (
        .clock(clock), .reset(reset),
        .wolv_dispInstValid(inst_valid), .wolv_dispInstData(inst_data),
        .wolv_dispRegID(reg_id), .wolv_dispRegRead(reg_read),
        .wolv_dispRegWrite(reg_write), .wolv_dispRegWrData(reg_wr_data),
        .wolv_dispAegCnt(d1_aeg_cnt), .wolv_dispException(d1_exc),
        .wolv_dispIdle(d1_idle), .wolv_dispRtnValid(d1_rtn_v),
        .wolv_dispRtnData(d1_rtn_d), .wolv_dispStall(d1_stall),
        .wolv_start(d1_start), .wolv_startOp(d1_op), .wolv_done(done),
        .wolv_aegRdIdx(aeg_rd_idx), .wolv_aegRdData(d1_aeg_rd),
        .wolv_resWrValid(res_wr_valid), .wolv_resWrIdx(res_wr_idx),
        .wolv_resWrData(res_wr_data)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Pop the scoreboard for every read return seen on dut0.
    task automatic sb_step();
        logic [63:0] e;
        if (d0_rtn_v === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("rtn_unexpected", {63'd0, d0_rtn_v}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("rtn_data", d0_rtn_d, e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        sb_step();
    endtask

    task automatic clear_inputs();
        inst_valid   = 1'b0;
        inst_data    = 5'd0;
        reg_id       = 18'd0;
        reg_read     = 1'b0;
        reg_write    = 1'b0;
        reg_wr_data  = 64'd0;
        done         = 1'b0;
        res_wr_valid = 1'b0;
        res_wr_idx   = 18'd0;
        res_wr_data  = 64'd0;
    endtask

    task automatic host_read(input logic [17:0] idx, input logic [63:0] exp);
        reg_read = 1'b1;
        reg_id   = idx;
        exp_q.push_back(exp);
        tick();
        reg_read = 1'b0;
    endtask

    initial begin
        clear_inputs();
        aeg_rd_idx = 18'd0;
        reset      = 1'b1;

        vecs[0] = '{1'b1, 1'b0, 18'd5,  64'd0,                    64'd0};
        vecs[1] = '{1'b0, 1'b1, 18'd3,  64'hDEADBEEF_00000001,    64'd0};
        vecs[2] = '{1'b1, 1'b0, 18'd3,  64'd0,                    64'hDEADBEEF_00000001};
        vecs[3] = '{1'b1, 1'b1, 18'd4,  64'd7,                    64'd0};
        vecs[4] = '{1'b1, 1'b0, 18'd4,  64'd0,                    64'd7};
        vecs[5] = '{1'b0, 1'b1, 18'd15, 64'hFFFF_FFFF_FFFF_FFFF,  64'd0};
        vecs[6] = '{1'b1, 1'b0, 18'd15, 64'd0,                    64'hFFFF_FFFF_FFFF_FFFF};
        vecs[7] = '{1'b1, 1'b0, 18'd0,  64'd0,                    64'd0};
        vecs[8] = '{1'b0, 1'b1, 18'd0,  64'h0000_0000_0000_0123,  64'd0};
        vecs[9] = '{1'b1, 1'b0, 18'd0,  64'd0,                    64'h0000_0000_0000_0123};

        // Reset state.
        repeat (3) tick();
        check("rst_idle",  {63'd0, d0_idle},  64'd1);
        check("rst_stall", {63'd0, d0_stall}, 64'd0);
        reset = 1'b0;
        tick();
        check("post_rst_idle",  {63'd0, d0_idle},  64'd1);
        check("post_rst_stall", {63'd0, d0_stall}, 64'd0);
        check("post_rst_start", {63'd0, d0_start}, 64'd0);
        check("post_rst_op",    {59'd0, d0_op},    64'd0);
        check("post_rst_exc",   {48'd0, d0_exc},   64'd0);
        check("post_rst_rtnv",  {63'd0, d0_rtn_v}, 64'd0);
        check("aeg_cnt",        {46'd0, d0_aeg_cnt}, 64'd16);

        // Host register access table.
        for (int i = 0; i < 10; i++) begin
            reg_read    = vecs[i].rd;
            reg_write   = vecs[i].wr;
            reg_id      = vecs[i].idx;
            reg_wr_data = vecs[i].wdata;
            if (vecs[i].rd) begin
                exp_q.push_back(vecs[i].exp);
            end
            tick();
        end
        clear_inputs();
        aeg_rd_idx = 18'd3;
        #1;
        check("core_rd_aeg3", d0_aeg_rd, 64'hDEADBEEF_00000001);
        check("table_exc", {48'd0, d0_exc}, 64'd0);

        // Dispatch: opcode 0x1A sampled at T, done sampled at T+5.
        inst_valid = 1'b1;
        inst_data  = 5'h1A;
        tick();
        inst_valid = 1'b0;
        inst_data  = 5'd0;
        check("launch_start", {63'd0, d0_start}, 64'd1);
        check("launch_op",    {59'd0, d0_op},    64'h1A);
        check("launch_idle",  {63'd0, d0_idle},  64'd0);
        check("launch_stall", {63'd0, d0_stall}, 64'd1);
        tick();
        check("busy_start", {63'd0, d0_start}, 64'd0);
        check("busy_stall", {63'd0, d0_stall}, 64'd1);
        repeat (3) tick();
        check("busy_idle_t4", {63'd0, d0_idle}, 64'd0);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("done_idle",  {63'd0, d0_idle},  64'd1);
        check("done_stall", {63'd0, d0_stall}, 64'd0);

        // Instruction and host write while BUSY are rejected.
        inst_valid = 1'b1;
        inst_data  = 5'h05;
        tick();
        inst_valid = 1'b0;
        tick();
        inst_valid = 1'b1;
        inst_data  = 5'h1F;
        tick();
        inst_valid = 1'b0;
        check("busy_inst_nostart", {63'd0, d0_start}, 64'd0);
        check("busy_inst_op",      {59'd0, d0_op},    64'h05);
        check("busy_inst_exc",     {48'd0, d0_exc},   64'h0001);
        reg_write   = 1'b1;
        reg_id      = 18'd2;
        reg_wr_data = 64'd9;
        tick();
        reg_write = 1'b0;
        check("busy_wr_exc", {48'd0, d0_exc}, 64'h0011);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("done2_idle", {63'd0, d0_idle}, 64'd1);
        host_read(18'd2, 64'd0);

        // done while IDLE is ignored.
        done = 1'b1;
        tick();
        done = 1'b0;
        check("idle_done_start", {63'd0, d0_start}, 64'd0);
        check("idle_done_idle",  {63'd0, d0_idle},  64'd1);

        // Range errors.
        host_read(18'd16, 64'd0);
        check("oor_read_exc", {48'd0, d0_exc}, 64'h0013);
        res_wr_valid = 1'b1;
        res_wr_idx   = 18'd20;
        res_wr_data  = 64'h0BAD;
        tick();
        res_wr_valid = 1'b0;
        check("oor_core_exc", {48'd0, d0_exc}, 64'h0033);
        aeg_rd_idx = 18'd4;
        #1;
        check("oor_core_nochg", d0_aeg_rd, 64'd7);
        aeg_rd_idx = 18'd20;
        #1;
        check("core_rd_oor", d0_aeg_rd, 64'd0);

        // Core write in range, then host/core collision.
        res_wr_valid = 1'b1;
        res_wr_idx   = 18'd6;
        res_wr_data  = 64'h66;
        tick();
        res_wr_valid = 1'b0;
        aeg_rd_idx   = 18'd6;
        #1;
        check("core_wr_aeg6", d0_aeg_rd, 64'h66);
        reg_write    = 1'b1;
        reg_id       = 18'd1;
        reg_wr_data  = 64'd1;
        res_wr_valid = 1'b1;
        res_wr_idx   = 18'd1;
        res_wr_data  = 64'd2;
        tick();
        clear_inputs();
        host_read(18'd1, 64'd1);
        check("prio_exc", {48'd0, d0_exc}, 64'h0033);

        // Watchdog on dut1 (TIMEOUT=8); dut0 (TIMEOUT=0) stays BUSY.
        inst_valid = 1'b1;
        inst_data  = 5'h0C;
        tick();
        inst_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("wd_busy", {63'd0, d1_idle}, 64'd0);
        end
        tick();
        check("wd_idle",  {63'd0, d1_idle},  64'd1);
        check("wd_stall", {63'd0, d1_stall}, 64'd0);
        check("wd_exc",   {48'd0, d1_exc},   64'h003B);
        check("nowd_busy", {63'd0, d0_idle}, 64'd0);
        check("nowd_exc",  {48'd0, d0_exc},  64'h0033);

        // Reset asserted mid-BUSY.
        reset = 1'b1;
        tick();
        check("midrst_idle",  {63'd0, d0_idle},  64'd1);
        check("midrst_stall", {63'd0, d0_stall}, 64'd0);
        reset = 1'b0;
        tick();
        tick();
        aeg_rd_idx = 18'd1;
        #1;
        check("midrst_exc",   {48'd0, d0_exc},    64'd0);
        check("midrst_start", {63'd0, d0_start},  64'd0);
        check("midrst_idle2", {63'd0, d0_idle},   64'd1);
        check("midrst_aeg",   d0_aeg_rd,          64'd0);
        check("d1_rst_exc",   {48'd0, d1_exc},    64'd0);
        check("d1_rst_cnt",   {46'd0, d1_aeg_cnt}, 64'd16);
        check("d1_rst_rtnv",  {63'd0, d1_rtn_v},  64'd0);
        check("d1_rst_rtnd",  d1_rtn_d,           64'd0);
        check("d1_rst_start", {63'd0, d1_start},  64'd0);
        check("d1_rst_op",    {59'd0, d1_op},     64'd0);
        check("d1_rst_aeg",   d1_aeg_rd,          64'd0);
        check("sb_drain",     64'(exp_q.size()),  64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wolverine_aeg_dispatch.md
# wolverine_aeg_dispatch

Accelerator-side consumer of the Wolverine dispatch interface driven by the simulated host test harness. Holds the AEG (application engine register) file, answers host register reads/writes, and turns dispatched instructions into a one-cycle start pulse to the compute core. Tracks core busy/done with a watchdog, and reports idle, stall and sticky exception status back to the host.

## Interface
Parameters:
- AEG_CNT, 16: number of 64-bit AEG registers (1..2^18-1).
- TIMEOUT, 0: BUSY watchdog limit in cycles; 0 disables it.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- wolv_dispInstValid  in  1  host dispatches instruction.
- wolv_dispInstData  in  5  instruction opcode.
- wolv_dispRegID  in  18  AEG index for the host access.
- wolv_dispRegRead  in  1  host register read.
- wolv_dispRegWrite  in  1  host register write.
- wolv_dispRegWrData  in  64  host write data.
- wolv_dispAegCnt  out  18  constant AEG_CNT.
- wolv_dispException  out  16  sticky exception bits.
- wolv_dispIdle  out  1  engine idle.
- wolv_dispRtnValid  out  1  read return valid.
- wolv_dispRtnData  out  64  read return data.
- wolv_dispStall  out  1  engine cannot accept an instruction.
- wolv_start  out  1  one-cycle launch pulse to the core.
- wolv_startOp  out  5  opcode latched at dispatch.
- wolv_done  in  1  core completion pulse.
- wolv_aegRdIdx  in  18  core read index.
- wolv_aegRdData  out  64  combinational core read data; 0 if the index is out of range.
- wolv_resWrValid  in  1  core result write.
- wolv_resWrIdx  in  18  core write index.
- wolv_resWrData  in  64  core write data.

## Operation
- FSM states: IDLE, LAUNCH, BUSY. Reset state is IDLE.
- IDLE to LAUNCH on dispInstValid; the opcode is latched into startOp.
- LAUNCH to BUSY unconditionally. start=1 only in LAUNCH. done is ignored in LAUNCH.
- BUSY to IDLE on done.
- BUSY to IDLE on watchdog expiry when TIMEOUT≠0: the cycle counter clears on entry to BUSY and expires after TIMEOUT BUSY cycles without done; sets exc[3].
- dispInstValid while not IDLE: ignored; sets exc[0]. done while IDLE: ignored.
- Host read:
  - Valid index: returns the register value as of the cycle of the request (pre-write).
  - Index ≥ AEG_CNT: rtnData=0 and exc[1] set.
  - rtnValid is asserted for every read request, one pulse per request.
- Host write:
  - Performed only in IDLE with index < AEG_CNT.
  - Out-of-range index: sets exc[1].
  - Write while not IDLE: dropped; sets exc[4].
- Read and write in the same cycle: both performed; the read returns the old value.
- Core write:
  - Accepted in any state with index < AEG_CNT.
  - Out-of-range index: dropped; sets exc[5].
  - Same index as an accepted host write in the same cycle: host wins.
- Exception bits are OR-accumulated and cleared only by reset. exc[15:6] are tied to 0.
- AEG registers reset to 0.

## Timing
- Values during and after reset, all outputs registered:
  - dispIdle=1.
  - All other outputs 0: dispStall, start, startOp, rtnValid, rtnData, dispException.
  - dispAegCnt=AEG_CNT at all times.
- Dispatch timing, instruction sampled at edge T:
  - start=1 and dispStall=1 and dispIdle=0 during cycle T+1.
  - BUSY from T+1 edge onward; dispStall=1 in LAUNCH and BUSY.
- Completion: done sampled at edge D gives dispIdle=1 and dispStall=0 during D+1. A new instruction is accepted at D+1.
- Read latency: request sampled at edge T gives rtnValid/rtnData valid during cycle T+1. Back-to-back reads are fully pipelined.
- Write timing: a write sampled at T is visible to a host read sampled at T+1 and to wolv_aegRdData from T+1.
- Reset asserted mid-BUSY: FSM goes to IDLE, registers and exceptions clear, and no start pulse is issued.

## Test plan
- Reset then idle: hold reset 3 cycles, release → dispIdle=1, dispStall=0, dispException=0, dispAegCnt=16, and reading AEG[5] returns 0 one cycle later.
- Write/read: write AEG[3]=0xDEADBEEF_00000001, read AEG[3] next cycle → rtnValid one cycle after the read, data 0xDEADBEEF_00000001. Same-cycle read+write of AEG[4]=7 → returns 0, and a following read returns 7.
- Dispatch: opcode 0x1A at T → start=1 with startOp=0x1A at T+1 only; idle=0 and stall=1. done at T+5 → idle=1 at T+6. A second instruction during BUSY → exc[0]=1 and no start pulse.
- Range errors: read AEG[16] → rtnData=0 and exc[1]. Core write to index 20 → exc[5], and the AEG file is unchanged.
- Write during BUSY and priority: host write AEG[2]=9 while BUSY → dropped, exc[4]. In IDLE, host writes AEG[1]=1 and core writes AEG[1]=2 in the same cycle → AEG[1] reads 1.
- Watchdog: TIMEOUT=8, dispatch with no done → IDLE and exc[3]=1 after 8 BUSY cycles. Reset asserted mid-BUSY → IDLE and all exception bits clear.
